// File: rtl/apb_mailbox_fifo.sv
// Bidirectional APB word mailbox: MCU writes feed a TX FIFO drained by a fabric
// valid/ready stream; a fabric valid/ready stream fills an RX FIFO that MCU reads
// pop. Status, flush and sticky error bits are register-mapped.
module apb_mailbox_fifo #(
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic                  pclk,
   input  logic                  preset_n,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [15:0]           pwdata,
   input  logic [1:0]            pstrb,
   output logic                  pready,
   output logic [15:0]           prdata,
   output logic                  pslverr,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [15:0]           tx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   input  logic [15:0]           rx_data,
   output logic                  irq_rx
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {IDLE, ACC_WAIT, DONE} apb_state_t;
   typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_OVF, OP_CTRL} wr_op_t;

   apb_state_t     state;
   wr_op_t         wr_op;
   wr_op_t         wr_op_dec;

   logic [15:0]    tx_mem [DEPTH];
   logic [PW-1:0]  tx_wr_ptr, tx_rd_ptr;
   logic [CW-1:0]  tx_count;
   logic [15:0]    rx_mem [DEPTH];
   logic [PW-1:0]  rx_wr_ptr, rx_rd_ptr;
   logic [CW-1:0]  rx_count, rx_next_count;
   logic           tx_ovf, rx_unf;

   logic           addr_ok;
   logic [2:0]     off;
   logic           wr_err;
   logic           commit, tx_push, ctrl_wr, flush_tx, flush_rx, clr_sticky, set_ovf;
   logic           rd_fire, rd_rx, rd_stat, rx_pop, set_unf;
   logic           tx_full, tx_empty, rx_full, rx_empty;
   logic           tx_pop, tx_load, tx_mem_nonempty, rx_push;
   logic [15:0]    status;
   logic           unused_addr_lsb;

   assign unused_addr_lsb = paddr[0];

   assign addr_ok = (paddr[ADDR_WIDTH-1:4] == '0);
   assign off     = paddr[3:1];

   assign tx_full  = (tx_count == CW'(DEPTH));
   assign tx_empty = (tx_count == '0);
   assign rx_full  = (rx_count == CW'(DEPTH));
   assign rx_empty = (rx_count == '0);

   // Write decode, evaluated in the setup cycle; the full check happens here
   // so a same-cycle fabric pop cannot turn a rejected push into an accepted one.
   always_comb begin
      wr_op_dec = OP_NONE;
      if (addr_ok && off == 3'd0 && pstrb == 2'b11)
         wr_op_dec = tx_full ? OP_OVF : OP_PUSH;
      else if (addr_ok && off == 3'd3 && pstrb[0])
         wr_op_dec = OP_CTRL;
   end

   assign wr_err     = (wr_op_dec == OP_NONE) || (wr_op_dec == OP_OVF);
   assign commit     = (state == DONE) && psel && penable;
   assign tx_push    = commit && (wr_op == OP_PUSH);
   assign set_ovf    = commit && (wr_op == OP_OVF);
   assign ctrl_wr    = commit && (wr_op == OP_CTRL);
   assign flush_tx   = ctrl_wr && pwdata[0];
   assign flush_rx   = ctrl_wr && pwdata[1];
   assign clr_sticky = ctrl_wr && pwdata[2];

   assign rd_fire = (state == ACC_WAIT) && psel && penable;
   assign rd_rx   = rd_fire && addr_ok && (off == 3'd1);
   assign rd_stat = rd_fire && addr_ok && (off == 3'd2);
   assign rx_pop  = rd_rx && !rx_empty;
   assign set_unf = rd_rx && rx_empty;

   always_comb begin
      status        = '0;
      status[0]     = tx_full;
      status[1]     = tx_empty;
      status[2]     = rx_full;
      status[3]     = rx_empty;
      status[4]     = tx_ovf;
      status[5]     = rx_unf;
      status[15:8]  = 8'(rx_count);
   end

   // APB completer FSM: zero-wait writes, one-wait reads, registered response
   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         state   <= IDLE;
         wr_op   <= OP_NONE;
         pready  <= 1'b0;
         pslverr <= 1'b0;
         prdata  <= '0;
      end else begin
         pready  <= 1'b0;
         pslverr <= 1'b0;
         prdata  <= '0;
         case (state)
            IDLE: begin
               if (psel && !penable) begin
                  if (pwrite) begin
                     state   <= DONE;
                     wr_op   <= wr_op_dec;
                     pready  <= 1'b1;
                     pslverr <= wr_err;
                  end else begin
                     state <= ACC_WAIT;
                     wr_op <= OP_NONE;
                  end
               end
            end
            ACC_WAIT: begin
               if (!psel) begin
                  state <= IDLE;
               end else if (penable) begin
                  state   <= DONE;
                  pready  <= 1'b1;
                  pslverr <= !(rd_stat || rx_pop);
                  if (rd_stat)
                     prdata <= status;
                  else if (rx_pop)
                     prdata <= rx_mem[rx_rd_ptr];
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky error bits; a new error outranks a same-cycle clear
   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         tx_ovf <= 1'b0;
         rx_unf <= 1'b0;
      end else begin
         if (set_ovf)         tx_ovf <= 1'b1;
         else if (clr_sticky) tx_ovf <= 1'b0;
         if (set_unf)         rx_unf <= 1'b1;
         else if (clr_sticky) rx_unf <= 1'b0;
      end
   end

   // tx_count covers memory plus the output register, so the memory holds
   // tx_count - tx_valid words; the head register refills from memory one edge
   // after a push lands, giving the two-cycle fall-through.
   assign tx_pop          = tx_valid && tx_ready;
   assign tx_mem_nonempty = (tx_count != {{(CW-1){1'b0}}, tx_valid});
   assign tx_load         = tx_mem_nonempty && (!tx_valid || tx_pop);

   // TX storage write port
   always_ff @(posedge pclk) begin
      if (tx_push)
         tx_mem[tx_wr_ptr] <= pwdata;
   end

   // TX pointers, occupancy and registered head word
   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
         tx_valid  <= 1'b0;
         tx_data   <= '0;
      end else if (flush_tx) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
         tx_valid  <= 1'b0;
      end else begin
         if (tx_push)
            tx_wr_ptr <= tx_wr_ptr + PW'(1);
         if (tx_load) begin
            tx_data   <= tx_mem[tx_rd_ptr];
            tx_rd_ptr <= tx_rd_ptr + PW'(1);
            tx_valid  <= 1'b1;
         end else if (tx_pop) begin
            tx_valid  <= 1'b0;
         end
         tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
      end
   end

   assign rx_push       = rx_valid && rx_ready;
   assign rx_next_count = rx_count + CW'(rx_push) - CW'(rx_pop);

   // RX storage write port
   always_ff @(posedge pclk) begin
      if (rx_push && !flush_rx)
         rx_mem[rx_wr_ptr] <= rx_data;
   end

   // RX pointers, occupancy, back-pressure and interrupt
   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
         rx_ready  <= 1'b0;
         irq_rx    <= 1'b0;
      end else if (flush_rx) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
         rx_ready  <= 1'b1;
         irq_rx    <= 1'b0;
      end else begin
         if (rx_push)
            rx_wr_ptr <= rx_wr_ptr + PW'(1);
         if (rx_pop)
            rx_rd_ptr <= rx_rd_ptr + PW'(1);
         rx_count <= rx_next_count;
         rx_ready <= (rx_next_count != CW'(DEPTH));
         irq_rx   <= (rx_next_count != '0);
      end
   end

endmodule

// File: tb/tb_apb_mailbox_fifo.sv
// Directed bench for apb_mailbox_fifo: APB responses and TX stream words are
// queued as expectations by the stimulus and checked by a separate monitor.
module tb_apb_mailbox_fifo;

   logic        pclk = 1'b0;
   logic        preset_n = 1'b0;
   logic [11:0] paddr = '0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [15:0] pwdata = '0;
   logic [1:0]  pstrb = '0;
   logic        pready;
   logic [15:0] prdata;
   logic        pslverr;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [15:0] tx_data;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [15:0] rx_data = '0;
   logic        irq_rx;

   typedef struct {
      logic        wr;
      logic        err;
      logic [15:0] rd;
   } exp_t;

   exp_t        apb_q[$];
   logic [15:0] tx_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          rx_acc = 0;
   logic        last_pready = 1'b0;

   apb_mailbox_fifo #(.DEPTH(32), .ADDR_WIDTH(12)) dut (
      .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready), .prdata(prdata), .pslverr(pslverr),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .irq_rx(irq_rx)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   // Response monitor: pops expectations whenever the DUT completes a transfer or a stream beat
   always @(negedge pclk) begin
      exp_t e;
      if (pready) begin
         if (apb_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_pready: got 1 expected 0 at %0t", $time);
         end else begin
            e = apb_q.pop_front();
            chk("pslverr", {15'd0, pslverr}, {15'd0, e.err});
            if (!e.wr) chk("prdata", prdata, e.rd);
         end
      end else if (last_pready) begin
         chk("prdata_after_pready", prdata, 16'h0000);
      end
      last_pready = pready;
      if (tx_valid && tx_ready) begin
         if (tx_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_tx_word: got 0x%04h expected none at %0t", tx_data, $time);
         end else begin
            chk("tx_data_stream", tx_data, tx_q.pop_front());
         end
      end
      if (rx_valid && rx_ready) rx_acc++;
   end

   task automatic apb(input logic wr, input logic [11:0] a, input logic [15:0] d,
                      input logic [1:0] s, input logic e_err, input logic [15:0] e_rd);
      exp_t e;
      int   lat;
      lat = -1;
      e.wr = wr; e.err = e_err; e.rd = e_rd;
      apb_q.push_back(e);
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
      @(posedge pclk); #1;
      penable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge pclk);
         if (pready) begin
            lat = i;
            break;
         end
      end
      chk(wr ? "write_wait_states" : "read_wait_states", 16'(lat), wr ? 16'd0 : 16'd1);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_wr(input logic [11:0] a, input logic [15:0] d, input logic [1:0] s, input logic e_err);
      apb(1'b1, a, d, s, e_err, 16'h0000);
   endtask

   task automatic apb_rd(input logic [11:0] a, input logic e_err, input logic [15:0] e_rd);
      apb(1'b0, a, 16'h0000, 2'b00, e_err, e_rd);
   endtask

   // Offer one fabric word and wait (bounded) for it to be taken
   task automatic rx_send(input logic [15:0] d);
      logic taken;
      taken = 1'b0;
      @(posedge pclk); #1;
      rx_valid = 1'b1; rx_data = d;
      for (int i = 0; i < 8; i++) begin
         @(negedge pclk);
         if (rx_ready) begin
            taken = 1'b1;
            break;
         end
      end
      chk("rx_word_taken", {15'd0, taken}, 16'h0001);
      @(posedge pclk); #1;
      rx_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1: read attempted while reset is held never completes
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h004;
      @(posedge pclk); #1;
      penable = 1'b1;
      repeat (3) begin
         @(negedge pclk);
         chk("reset_no_pready", {15'd0, pready}, 16'h0000);
      end
      chk("reset_tx_valid", {15'd0, tx_valid}, 16'h0000);
      chk("reset_rx_ready", {15'd0, rx_ready}, 16'h0000);
      chk("reset_irq_rx", {15'd0, irq_rx}, 16'h0000);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0; preset_n = 1'b1;
      @(posedge pclk);
      @(negedge pclk);
      chk("rx_ready_after_release", {15'd0, rx_ready}, 16'h0001);
      apb_rd(12'h004, 1'b0, 16'h000A);

      // 2: single push shows on the TX stream two cycles after pready
      tx_q.push_back(16'h1234);
      apb_wr(12'h000, 16'h1234, 2'b11, 1'b0);
      @(negedge pclk);
      chk("tx_valid_cycle1", {15'd0, tx_valid}, 16'h0000);
      @(negedge pclk);
      chk("tx_valid_cycle2", {15'd0, tx_valid}, 16'h0001);
      chk("tx_data_head", tx_data, 16'h1234);

      // 3: fill TX, overflow, drain a few, flush with clear-sticky
      for (int i = 1; i < 32; i++) begin
         tx_q.push_back(16'h0100 + 16'(i));
         apb_wr(12'h000, 16'h0100 + 16'(i), 2'b11, 1'b0);
      end
      apb_wr(12'h000, 16'hDEAD, 2'b11, 1'b1);
      apb_rd(12'h004, 1'b0, 16'h0019);
      @(posedge pclk); #1;
      tx_ready = 1'b1;
      repeat (3) @(posedge pclk);
      #1;
      tx_ready = 1'b0;
      apb_wr(12'h006, 16'h0005, 2'b01, 1'b0);
      tx_q.delete();
      @(negedge pclk);
      chk("tx_valid_after_flush", {15'd0, tx_valid}, 16'h0000);
      apb_rd(12'h004, 1'b0, 16'h000A);

      // 4: two fabric words, read back in order, then underflow
      rx_send(16'hAAAA);
      rx_send(16'h5555);
      @(negedge pclk);
      chk("irq_rx_set", {15'd0, irq_rx}, 16'h0001);
      apb_rd(12'h004, 1'b0, 16'h0202);
      apb_rd(12'h002, 1'b0, 16'hAAAA);
      apb_rd(12'h002, 1'b0, 16'h5555);
      apb_rd(12'h002, 1'b1, 16'h0000);
      @(negedge pclk);
      chk("irq_rx_clear", {15'd0, irq_rx}, 16'h0000);
      apb_rd(12'h004, 1'b0, 16'h002A);

      // 5: bad strobes, bad offsets, wrong direction, upper address bits
      apb_wr(12'h000, 16'hBEEF, 2'b01, 1'b1);
      apb_rd(12'h008, 1'b1, 16'h0000);
      apb_wr(12'h004, 16'hFFFF, 2'b11, 1'b1);
      apb_rd(12'h006, 1'b1, 16'h0000);
      apb_rd(12'h000, 1'b1, 16'h0000);
      apb_rd(12'h104, 1'b1, 16'h0000);
      apb_wr(12'h006, 16'h0007, 2'b10, 1'b1);
      apb_rd(12'h005, 1'b0, 16'h002A);
      @(negedge pclk);
      chk("tx_valid_after_bad_push", {15'd0, tx_valid}, 16'h0000);
      apb_wr(12'h006, 16'h0004, 2'b01, 1'b0);
      apb_rd(12'h004, 1'b0, 16'h000A);

      // 6: RX full with rx_valid held, one APB pop lets exactly one more word in
      for (int k = 1; k <= 32; k++) rx_send(16'hC000 + 16'(k));
      @(posedge pclk); #1;
      rx_valid = 1'b1; rx_data = 16'hC021;
      repeat (2) begin
         @(negedge pclk);
         chk("rx_ready_full", {15'd0, rx_ready}, 16'h0000);
      end
      apb_rd(12'h004, 1'b0, 16'h2006);
      apb_rd(12'h002, 1'b0, 16'hC001);
      repeat (3) @(posedge pclk);
      #1;
      rx_valid = 1'b0;
      chk("rx_words_accepted", 16'(rx_acc), 16'd35);
      for (int k = 2; k <= 33; k++) apb_rd(12'h002, 1'b0, 16'hC000 + 16'(k));
      apb_rd(12'h004, 1'b0, 16'h000A);

      repeat (3) @(posedge pclk);
      chk("apb_expectations_left", 16'(apb_q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
